// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, flush and issue signals of the ALU reservation station.
// The master side is the dispatch/CDB/ALU environment. The slave side is the station.
interface alu_reservation_station_if #(
    parameter int WIDTH   = 31,
    parameter int A_WIDTH = 3,
    parameter int ROB     = 2
);
    logic                  flush;
    logic                  dispatchValid;
    logic [A_WIDTH:0]      dispatchControl;
    logic [ROB:0]          dispatchRob;
    logic [WIDTH:0]        dispatchSrc1;
    logic [WIDTH:0]        dispatchSrc2;
    logic                  dispatchSrc1Valid;
    logic                  dispatchSrc2Valid;
    logic [ROB:0]          dispatchSrc1Tag;
    logic [ROB:0]          dispatchSrc2Tag;
    logic                  full;
    logic                  cdbValid;
    logic [ROB:0]          cdbRob;
    logic [WIDTH:0]        cdbResult;
    logic                  aluAvailable;
    logic                  issueValid;
    logic signed [WIDTH:0] src1;
    logic signed [WIDTH:0] src2;
    logic [A_WIDTH:0]      ALUControl;
    logic [ROB:0]          ALURob;

    modport master (
        output flush, dispatchValid, dispatchControl, dispatchRob,
               dispatchSrc1, dispatchSrc2, dispatchSrc1Valid, dispatchSrc2Valid,
               dispatchSrc1Tag, dispatchSrc2Tag, cdbValid, cdbRob, cdbResult,
               aluAvailable,
        input  full, issueValid, src1, src2, ALUControl, ALURob
    );

    modport slave (
        input  flush, dispatchValid, dispatchControl, dispatchRob,
               dispatchSrc1, dispatchSrc2, dispatchSrc1Valid, dispatchSrc2Valid,
               dispatchSrc1Tag, dispatchSrc2Tag, cdbValid, cdbRob, cdbResult,
               aluAvailable,
        output full, issueValid, src1, src2, ALUControl, ALURob
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station. Entries hold operands or producer tags and wake up from the CDB.
// The oldest fully-ready entry is issued, with age tracked by an ENTRIES x ENTRIES matrix.
module alu_reservation_station #(
    parameter int WIDTH   = 31,
    parameter int A_WIDTH = 3,
    parameter int ROB     = 2,
    parameter int ENTRIES = 4
) (
    input  logic                      clk,
    input  logic                      globalReset,
    alu_reservation_station_if.slave  bus
);
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [A_WIDTH:0]   op_q  [ENTRIES];
    logic [A_WIDTH:0]   op_d  [ENTRIES];
    logic [ROB:0]       rob_q [ENTRIES];
    logic [ROB:0]       rob_d [ENTRIES];
    logic [ROB:0]       tag1_q[ENTRIES];
    logic [ROB:0]       tag1_d[ENTRIES];
    logic [ROB:0]       tag2_q[ENTRIES];
    logic [ROB:0]       tag2_d[ENTRIES];
    logic [WIDTH:0]     val1_q[ENTRIES];
    logic [WIDTH:0]     val1_d[ENTRIES];
    logic [WIDTH:0]     val2_q[ENTRIES];
    logic [WIDTH:0]     val2_d[ENTRIES];
    // age_q[i][j] = 1 means entry j is older than entry i
    logic [ENTRIES-1:0] age_q [ENTRIES];
    logic [ENTRIES-1:0] age_d [ENTRIES];

    logic               iv_q, iv_d;
    logic [WIDTH:0]     src1_q, src1_d, src2_q, src2_d;
    logic [A_WIDTH:0]   ctl_q, ctl_d;
    logic [ROB:0]       arob_q, arob_d;

    logic [ENTRIES-1:0] ready, sel, free_oh;
    logic               found;
    logic               do_disp, do_issue, byp1, byp2;

    assign bus.full       = &busy_q;
    assign bus.issueValid = iv_q;
    assign bus.src1       = src1_q;
    assign bus.src2       = src2_q;
    assign bus.ALUControl = ctl_q;
    assign bus.ALURob     = arob_q;

    assign do_disp  = bus.dispatchValid && !(&busy_q) && !bus.flush;
    assign do_issue = bus.aluAvailable && (|ready) && !bus.flush;
    assign byp1     = bus.cdbValid && (bus.cdbRob == bus.dispatchSrc1Tag);
    assign byp2     = bus.cdbValid && (bus.cdbRob == bus.dispatchSrc2Tag);

    // Ready vector and oldest-ready select (one-hot), from registered state only
    always_comb begin
        ready = '0;
        sel   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++)
            ready[i] = busy_q[i] & rdy1_q[i] & rdy2_q[i];
        for (int unsigned i = 0; i < ENTRIES; i++)
            sel[i] = ready[i] & ~(|(age_q[i] & ready));
    end

    // Lowest-index free entry (one-hot)
    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!busy_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Next-state: flush, else wakeup, issue and dispatch
    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        op_d   = op_q;
        rob_d  = rob_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        val1_d = val1_q;
        val2_d = val2_q;
        age_d  = age_q;
        iv_d   = 1'b0;
        src1_d = src1_q;
        src2_d = src2_q;
        ctl_d  = ctl_q;
        arob_d = arob_q;
        if (bus.flush) begin
            busy_d = '0;
            for (int unsigned i = 0; i < ENTRIES; i++)
                age_d[i] = '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && bus.cdbValid) begin
                    if (!rdy1_q[i] && tag1_q[i] == bus.cdbRob) begin
                        val1_d[i] = bus.cdbResult;
                        rdy1_d[i] = 1'b1;
                    end
                    if (!rdy2_q[i] && tag2_q[i] == bus.cdbRob) begin
                        val2_d[i] = bus.cdbResult;
                        rdy2_d[i] = 1'b1;
                    end
                end
            end
            if (do_issue) begin
                iv_d = 1'b1;
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (sel[i]) begin
                        src1_d    = val1_q[i];
                        src2_d    = val2_q[i];
                        ctl_d     = op_q[i];
                        arob_d    = rob_q[i];
                        busy_d[i] = 1'b0;
                    end
                end
            end
            if (do_disp) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (free_oh[i]) begin
                        busy_d[i] = 1'b1;
                        op_d[i]   = bus.dispatchControl;
                        rob_d[i]  = bus.dispatchRob;
                        tag1_d[i] = bus.dispatchSrc1Tag;
                        tag2_d[i] = bus.dispatchSrc2Tag;
                        rdy1_d[i] = bus.dispatchSrc1Valid | byp1;
                        rdy2_d[i] = bus.dispatchSrc2Valid | byp2;
                        val1_d[i] = bus.dispatchSrc1Valid ? bus.dispatchSrc1 : bus.cdbResult;
                        val2_d[i] = bus.dispatchSrc2Valid ? bus.dispatchSrc2 : bus.cdbResult;
                        // Drop stale "older" marks left by the previous occupant of this slot
                        for (int unsigned k = 0; k < ENTRIES; k++)
                            age_d[k][i] = 1'b0;
                        age_d[i] = busy_q;
                    end
                end
            end
        end
    end

    // State and issue registers
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            op_q   <= '{default: '0};
            rob_q  <= '{default: '0};
            tag1_q <= '{default: '0};
            tag2_q <= '{default: '0};
            val1_q <= '{default: '0};
            val2_q <= '{default: '0};
            age_q  <= '{default: '0};
            iv_q   <= 1'b0;
            src1_q <= '0;
            src2_q <= '0;
            ctl_q  <= '0;
            arob_q <= '0;
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            op_q   <= op_d;
            rob_q  <= rob_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            val1_q <= val1_d;
            val2_q <= val2_d;
            age_q  <= age_d;
            iv_q   <= iv_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            ctl_q  <= ctl_d;
            arob_q <= arob_d;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station. Directed scenarios are followed by random traffic.
// A reference model keeps waiting ops in a queue in dispatch order.
module tb_alu_reservation_station;
    logic clk = 1'b0;
    logic globalReset = 1'b1;
    always #5 clk = ~clk;

    alu_reservation_station_if bus ();

    alu_reservation_station dut (
        .clk         (clk),
        .globalReset (globalReset),
        .bus         (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rob;
        logic [2:0]  t1, t2;
        logic        r1, r2;
        logic [31:0] v1, v2;
    } ent_t;

    ent_t        mq[$];
    logic        m_iv;
    logic [31:0] m_s1, m_s2;
    logic [3:0]  m_ctl;
    logic [2:0]  m_rob;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_iv = 0; m_s1 = 0; m_s2 = 0; m_ctl = 0; m_rob = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        int   sel;
        int   pre_size;
        ent_t e;
        if (bus.flush) begin
            mq.delete();
            m_iv = 0;
            return;
        end
        pre_size = mq.size();
        sel = -1;
        if (bus.aluAvailable)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].r1 && mq[i].r2) begin sel = i; break; end
        if (bus.cdbValid)
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].r1 && mq[i].t1 == bus.cdbRob) begin mq[i].r1 = 1; mq[i].v1 = bus.cdbResult; end
                if (!mq[i].r2 && mq[i].t2 == bus.cdbRob) begin mq[i].r2 = 1; mq[i].v2 = bus.cdbResult; end
            end
        if (sel >= 0) begin
            m_iv = 1; m_s1 = mq[sel].v1; m_s2 = mq[sel].v2;
            m_ctl = mq[sel].op; m_rob = mq[sel].rob;
            mq.delete(sel);
        end else m_iv = 0;
        if (bus.dispatchValid && pre_size < 4) begin
            e.op = bus.dispatchControl; e.rob = bus.dispatchRob;
            e.t1 = bus.dispatchSrc1Tag; e.t2 = bus.dispatchSrc2Tag;
            e.r1 = 0; e.r2 = 0; e.v1 = 0; e.v2 = 0;
            if (bus.dispatchSrc1Valid) begin e.r1 = 1; e.v1 = bus.dispatchSrc1; end
            else if (bus.cdbValid && bus.cdbRob == e.t1) begin e.r1 = 1; e.v1 = bus.cdbResult; end
            if (bus.dispatchSrc2Valid) begin e.r2 = 1; e.v2 = bus.dispatchSrc2; end
            else if (bus.cdbValid && bus.cdbRob == e.t2) begin e.r2 = 1; e.v2 = bus.cdbResult; end
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        check("issueValid", bus.issueValid, m_iv);
        check("full", bus.full, (mq.size() == 4));
        check("src1", bus.src1, m_s1);
        check("src2", bus.src2, m_s2);
        check("ALUControl", bus.ALUControl, m_ctl);
        check("ALURob", bus.ALURob, m_rob);
    endtask

    // One clock: model update, edge, then compare at the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.dispatchValid = 0; bus.cdbValid = 0;
        bus.aluAvailable = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [2:0] rob,
                        input logic v1ok, input logic [31:0] v1, input logic [2:0] t1,
                        input logic v2ok, input logic [31:0] v2, input logic [2:0] t2);
        bus.dispatchValid = 1; bus.dispatchControl = op; bus.dispatchRob = rob;
        bus.dispatchSrc1Valid = v1ok; bus.dispatchSrc1 = v1; bus.dispatchSrc1Tag = t1;
        bus.dispatchSrc2Valid = v2ok; bus.dispatchSrc2 = v2; bus.dispatchSrc2Tag = t2;
    endtask

    task automatic cdb(input logic [2:0] rob, input logic [31:0] res);
        bus.cdbValid = 1; bus.cdbRob = rob; bus.cdbResult = res;
    endtask

    initial begin
        idle_inputs();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        bus.dispatchValid = 0;
        cdb(0, 0);
        bus.cdbValid = 0;
        model_reset();
        #12;
        check("rst_issueValid", bus.issueValid, 0);
        check("rst_full", bus.full, 0);
        @(negedge clk);
        globalReset = 0;
        @(negedge clk);

        // Reset mid-operation: three waiting entries, then asynchronous reset
        for (int i = 0; i < 3; i++) begin
            disp(1, 3'(i), 0, 0, 3'(4 + i), 1, 9, 0);
            tick();
        end
        idle_inputs();
        #2 globalReset = 1;
        model_reset();
        #1;
        check_all();
        check("midrst_src1", bus.src1, 0);
        @(negedge clk);
        globalReset = 0;

        // Ready dispatch: issue one cycle later, then one-cycle pulse
        disp(4'h0, 3, 1, 5, 0, 1, 7, 0);
        bus.aluAvailable = 1;
        tick();
        check("rdy_iv_early", bus.issueValid, 0);
        bus.dispatchValid = 0;
        tick();
        check("rdy_iv", bus.issueValid, 1);
        check("rdy_src1", bus.src1, 5);
        check("rdy_src2", bus.src2, 7);
        check("rdy_rob", bus.ALURob, 3);
        check("rdy_ctl", bus.ALUControl, 0);
        tick();
        check("rdy_iv_drop", bus.issueValid, 0);

        // Same-cycle CDB bypass at dispatch
        disp(4'h2, 1, 0, 0, 6, 1, 1, 0);
        cdb(6, 32'hFFFF_FFF0);
        tick();
        idle_inputs(); bus.aluAvailable = 1;
        tick();
        check("byp_iv", bus.issueValid, 1);
        check("byp_src1", bus.src1, 32'hFFFF_FFF0);
        idle_inputs();
        tick();

        // Age order: A waits, B ready, wake A while ALU busy, then A then B
        disp(4'h3, 4, 0, 0, 2, 1, 11, 0);
        tick();
        disp(4'h5, 5, 1, 21, 0, 1, 22, 0);
        tick();
        idle_inputs(); cdb(2, 32'd100);
        tick();
        idle_inputs(); bus.aluAvailable = 1;
        tick();
        check("age_first", bus.ALURob, 4);
        check("age_first_src1", bus.src1, 100);
        tick();
        check("age_second", bus.ALURob, 5);
        check("age_second_iv", bus.issueValid, 1);
        idle_inputs();
        tick();

        // Full / backpressure
        for (int i = 0; i < 4; i++) begin
            disp(4'h1, 3'(i), 0, 0, 3'(4 + i), 1, 3, 0);
            tick();
        end
        check("full_set", bus.full, 1);
        disp(4'h7, 7, 1, 1, 0, 1, 1, 0);
        tick();
        check("full_ignored_iv", bus.issueValid, 0);
        idle_inputs(); cdb(4, 32'd44);
        tick();
        idle_inputs(); bus.aluAvailable = 1;
        tick();
        check("full_issue_rob", bus.ALURob, 0);
        check("full_cleared", bus.full, 0);
        idle_inputs(); bus.flush = 1;
        tick();
        check("flush_empty", bus.full, 0);

        // Flush with an issue pending
        idle_inputs();
        disp(4'h6, 1, 1, 8, 0, 1, 9, 0);
        tick();
        disp(4'h6, 2, 0, 0, 3, 1, 9, 0);
        tick();
        idle_inputs(); bus.aluAvailable = 1; bus.flush = 1;
        tick();
        check("flush_iv", bus.issueValid, 0);
        check("flush_full", bus.full, 0);
        idle_inputs(); bus.aluAvailable = 1; cdb(3, 32'd5);
        tick();
        idle_inputs(); bus.aluAvailable = 1;
        tick();
        check("flush_no_issue", bus.issueValid, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.flush         = ($urandom_range(0, 59) == 0);
            bus.dispatchValid = $urandom_range(0, 1);
            bus.dispatchControl   = 4'($urandom);
            bus.dispatchRob       = 3'($urandom);
            bus.dispatchSrc1      = $urandom;
            bus.dispatchSrc2      = $urandom;
            bus.dispatchSrc1Valid = ($urandom_range(0, 2) == 0);
            bus.dispatchSrc2Valid = ($urandom_range(0, 2) == 0);
            bus.dispatchSrc1Tag   = 3'($urandom);
            bus.dispatchSrc2Tag   = 3'($urandom);
            bus.cdbValid      = $urandom_range(0, 1);
            bus.cdbRob        = 3'($urandom);
            bus.cdbResult     = $urandom;
            bus.aluAvailable  = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
